// File: rtl/axis_frame_capture_if.sv
// AXI4-Stream sample bus into the frame capture buffer.
// The master drives data/valid/last and the capture block returns ready.
interface axis_frame_capture_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_frame_capture.sv
// Armed capture of FRAMES x FFT_LEN stream samples into RAM; readback is registered (1 cycle), write is 0-latency.
// tready drops only while FULL when HOLD_ON_FULL=1; define CAPTURE_TLAST_ALIGN_EN to start capture after a tlast.
module axis_frame_capture #(
  parameter int WIDTH        = 32,
  parameter int FFT_LEN      = 64,
  parameter int FRAMES       = 20,
  parameter int SKIP_WID     = 8,
  parameter int HOLD_ON_FULL = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  arm,
  input  logic [SKIP_WID-1:0]                   skip_frames,
  axis_frame_capture_if.slave                   s_axis,
  output logic                                  busy,
  output logic                                  full,
  output logic [$clog2(FRAMES+1)-1:0]           frame_cnt,
  output logic                                  tlast_err,
  input  logic [$clog2(FRAMES*FFT_LEN)-1:0]     rd_addr,
  output logic [WIDTH-1:0]                      rd_data
);

  localparam int DEPTH  = FRAMES * FFT_LEN;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SAMP_W = $clog2(FFT_LEN);

  typedef enum logic [2:0] {IDLE, ALIGN, SKIP, CAPTURE, FULL} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic                start;
  logic                last_samp;
  logic                framing_on;
  logic                wr_en;
  logic [SAMP_W-1:0]   samp_idx;
  logic [ADDR_W-1:0]   wr_addr;
  logic [SKIP_WID-1:0] skip_cnt;
  logic [WIDTH-1:0]    ram [DEPTH];

  assign s_axis.tready = !rst && !((state == FULL) && (HOLD_ON_FULL != 0));
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign last_samp     = (samp_idx == SAMP_W'(FFT_LEN - 1));
  // arm is only honoured from the two resting states; busy states ignore it
  assign start         = arm && ((state == IDLE) || (state == FULL));
  assign framing_on    = (state == SKIP) || (state == CAPTURE);
  assign wr_en         = (state == CAPTURE) && accept;
  assign busy          = (state == ALIGN) || (state == SKIP) || (state == CAPTURE);
  assign full          = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FULL: begin
        if (arm) begin
`ifdef CAPTURE_TLAST_ALIGN_EN
          state_nxt = ALIGN;
`else
          // without alignment ALIGN is transparent: the next beat is already bin 0
          state_nxt = (skip_frames != '0) ? SKIP : CAPTURE;
`endif
        end
      end
      ALIGN: begin
`ifdef CAPTURE_TLAST_ALIGN_EN
        if (accept && s_axis.tlast) state_nxt = (skip_cnt != '0) ? SKIP : CAPTURE;
`else
        state_nxt = (skip_cnt != '0) ? SKIP : CAPTURE;
`endif
      end
      SKIP: begin
        if (accept && last_samp && (skip_cnt <= SKIP_WID'(1))) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (wr_en && (wr_addr == ADDR_W'(DEPTH - 1))) state_nxt = FULL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_idx  <= '0;
      wr_addr   <= '0;
      skip_cnt  <= '0;
      frame_cnt <= '0;
      tlast_err <= 1'b0;
    end else if (start) begin
      samp_idx  <= '0;
      wr_addr   <= '0;
      skip_cnt  <= skip_frames;
      frame_cnt <= '0;
      tlast_err <= 1'b0;
    end else if (accept && framing_on) begin
      // sample counter free-runs on accepted beats; a framing error never resyncs it
      samp_idx <= last_samp ? '0 : samp_idx + SAMP_W'(1);
      if (s_axis.tlast != last_samp) tlast_err <= 1'b1;
      if ((state == SKIP) && last_samp) skip_cnt <= skip_cnt - SKIP_WID'(1);
      if (state == CAPTURE) begin
        wr_addr <= wr_addr + ADDR_W'(1);
        if (last_samp) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= s_axis.tdata;
  end

  // read-first: a same-cycle write to rd_addr is seen one cycle later
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= ram[rd_addr];
  end

endmodule

// File: tb/tb_axis_frame_capture.sv
// Bench for axis_frame_capture: table-driven capture runs with a readback scoreboard, plus reset/read-first sequences.
module tb_axis_frame_capture;
  localparam int WIDTH    = 32;
  localparam int FFT_LEN  = 8;
  localparam int FRAMES   = 2;
  localparam int SKIP_WID = 8;
  localparam int DEPTH    = FFT_LEN * FRAMES;
`ifdef CAPTURE_TLAST_ALIGN_EN
  localparam int ALIGN_OFF = FFT_LEN;
`else
  localparam int ALIGN_OFF = 0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                arm;
  logic [SKIP_WID-1:0] skip_frames;
  logic                busy;
  logic                full;
  logic [1:0]          frame_cnt;
  logic                tlast_err;
  logic [3:0]          rd_addr;
  logic [WIDTH-1:0]    rd_data;

  axis_frame_capture_if #(.WIDTH(WIDTH)) s_axis ();

  axis_frame_capture #(
    .WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .FRAMES(FRAMES),
    .SKIP_WID(SKIP_WID), .HOLD_ON_FULL(1)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .skip_frames(skip_frames),
    .s_axis(s_axis), .busy(busy), .full(full), .frame_cnt(frame_cnt),
    .tlast_err(tlast_err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    int skip;
    bit gap;
    int err_at;
    int arm_mid;
    bit arm_end;
    bit exp_err;
    int exp_fc;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } sb_t;

  vec_t tbl [4];
  sb_t  sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    sb_t  e;
    int   cap0;
    int   n;
    int   busy_cyc;
    bit   m_err;
    int   m_fc;

    tbl[0] = '{skip: 0, gap: 0, err_at: -1, arm_mid: 10, arm_end: 0, exp_err: 0, exp_fc: 2};
    tbl[1] = '{skip: 2, gap: 1, err_at: -1, arm_mid: -1, arm_end: 0, exp_err: 0, exp_fc: 2};
    tbl[2] = '{skip: 0, gap: 0, err_at: 5,  arm_mid: -1, arm_end: 0, exp_err: 1, exp_fc: 2};
    tbl[3] = '{skip: 1, gap: 0, err_at: -1, arm_mid: -1, arm_end: 1, exp_err: 0, exp_fc: 2};

    rst = 1'b1; arm = 1'b0; skip_frames = '0; rd_addr = '0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0;
    tick; tick;
    check("rst_tready", s_axis.tready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_tlast_err", tlast_err, 1'b0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    #1;
    check("post_rst_tready", s_axis.tready, 1'b1);

    for (int t = 0; t < 4; t++) begin
      v        = tbl[t];
      cap0     = ALIGN_OFF + v.skip * FFT_LEN;
      n        = cap0 + DEPTH;
      busy_cyc = 0;
      m_err    = 1'b0;

      // arm edge carries a junk beat that must be discarded
      arm = 1'b1; skip_frames = SKIP_WID'(v.skip);
      s_axis.tvalid = 1'b1; s_axis.tdata = 32'hdead_0000; s_axis.tlast = 1'b0;
      tick;
      arm = 1'b0; s_axis.tvalid = 1'b0; skip_frames = SKIP_WID'(3);
      if (busy) busy_cyc++;
      check($sformatf("t%0d_arm_tready", t), s_axis.tready, 1'b1);
      check($sformatf("t%0d_arm_full", t), full, 1'b0);
      check($sformatf("t%0d_arm_fc", t), frame_cnt, 0);
      check($sformatf("t%0d_arm_err", t), tlast_err, 1'b0);

      for (int b = 0; b < n; b++) begin
        if (v.gap) begin
          s_axis.tvalid = 1'b0;
          tick;
          if (busy) busy_cyc++;
        end
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = b;
        s_axis.tlast  = ((b % FFT_LEN) == FFT_LEN - 1) ^ (v.err_at >= 0 && b == cap0 + v.err_at);
        arm = (b == v.arm_mid) || (v.arm_end && b == n - 1);
        if (b >= cap0) sb.push_back('{addr: 4'(b - cap0), data: b});
        if (b == n - 1) check($sformatf("t%0d_full_before_last", t), full, 1'b0);
        tick;
        arm = 1'b0;
        if (busy) busy_cyc++;
        if (v.err_at >= 0 && b == cap0 + v.err_at) m_err = 1'b1;
        m_fc = (b >= cap0) ? (b - cap0 + 1) / FFT_LEN : 0;
        check($sformatf("t%0d_b%0d_err", t, b), tlast_err, m_err);
        check($sformatf("t%0d_b%0d_fc", t, b), frame_cnt, m_fc);
      end
      s_axis.tvalid = 1'b0;

      check($sformatf("t%0d_full", t), full, 1'b1);
      check($sformatf("t%0d_busy_done", t), busy, 1'b0);
      check($sformatf("t%0d_fc_final", t), frame_cnt, v.exp_fc);
      check($sformatf("t%0d_err_final", t), tlast_err, v.exp_err);
      check($sformatf("t%0d_busy_cycles", t), busy_cyc, n * (v.gap ? 2 : 1));
      check($sformatf("t%0d_tready_full", t), s_axis.tready, 1'b0);

      // offered beat while full must not disturb anything
      s_axis.tvalid = 1'b1; s_axis.tdata = 32'hffff_ffff;
      tick;
      s_axis.tvalid = 1'b0;
      check($sformatf("t%0d_full_hold", t), full, 1'b1);

      while (sb.size() > 0) begin
        e = sb.pop_front();
        rd_addr = e.addr;
        tick;
        check($sformatf("t%0d_rd%0d", t, e.addr), rd_data, e.data);
      end
    end

    // re-arm from FULL, then abort mid-capture with rst; also checks read-first
    arm = 1'b1; skip_frames = '0;
    tick;
    arm = 1'b0;
    check("abort_arm_tready", s_axis.tready, 1'b1);
    if (ALIGN_OFF != 0) begin
      s_axis.tvalid = 1'b1; s_axis.tdata = 32'hbeef; s_axis.tlast = 1'b1;
      tick;
    end
    rd_addr = 4'd0;
    for (int b = 0; b < 5; b++) begin
      s_axis.tvalid = 1'b1; s_axis.tdata = 100 + b; s_axis.tlast = 1'b0;
      tick;
      if (b == 0) check("read_first_old", rd_data, ALIGN_OFF + FFT_LEN);
      if (b == 1) check("write_visible", rd_data, 100);
    end
    s_axis.tvalid = 1'b0;
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    tick;
    check("abort_busy", busy, 1'b0);
    check("abort_fc", frame_cnt, 0);
    check("abort_full", full, 1'b0);
    check("abort_err", tlast_err, 1'b0);
    rst = 1'b0;
    rd_addr = 4'd2;
    tick;
    check("abort_rd2", rd_data, 102);
    rd_addr = 4'd7;
    tick;
    check("abort_rd7_retained", rd_data, ALIGN_OFF + FFT_LEN + 7);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/axis_frame_capture.md
# axis_frame_capture

Parametrised AXI4-Stream capture buffer for the OSPFB output path; the successor to the fixed-size capture model used at the end of the ADC→FIFO→OSPFB chain. It records `FRAMES` frames of `FFT_LEN` samples each into on-chip RAM after a software arm, which makes it usable in hardware builds as well as in benches.
- Optional discard of a programmable number of leading frames before capture.
- Optional alignment to the stream `tlast` so that RAM word 0 is always FFT bin 0.
- Frame-framing checks, selectable backpressure when full, and a random-access readback port.

## Interface
- `WIDTH`, 32: sample width (complex re/im packed).
- `FFT_LEN`, 64: samples per frame; power of two, ≥4.
- `FRAMES`, 20: frames captured per arm; DEPTH = FRAMES*FFT_LEN.
- `SKIP_WID`, 8: width of the skip-frame count.
- `HOLD_ON_FULL`, 0: 1 deasserts `s_axis_tready` while FULL; 0 keeps it high and discards.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  one-cycle pulse that starts a capture.
- `skip_frames`  in  SKIP_WID  number of complete frames to discard before capture; sampled on the accepted `arm`.
- `s_axis_tdata`  in  WIDTH  stream data.
- `s_axis_tvalid`  in  1  stream valid.
- `s_axis_tlast`  in  1  marks the last sample of a frame.
- `s_axis_tready`  out  1  stream ready.
- `busy`  out  1  high in ALIGN, SKIP and CAPTURE.
- `full`  out  1  DEPTH samples have been stored.
- `frame_cnt`  out  $clog2(FRAMES+1)  completed captured frames.
- `tlast_err`  out  1  sticky framing error.
- `rd_addr`  in  $clog2(DEPTH)  readback address.
- `rd_data`  out  WIDTH  RAM word at `rd_addr`, registered.

## Operation
- A beat is accepted when `tvalid & tready`. Only accepted beats advance any counter.
- States are IDLE, ALIGN, SKIP, CAPTURE and FULL. Reset enters IDLE.
- IDLE: accepted beats are discarded. `arm` moves to ALIGN. It also latches `skip_frames` into `skip_cnt` and clears `wr_addr`, `samp_idx`, `frame_cnt` and `tlast_err`.
- ALIGN: see Configuration. On exit, go to SKIP if `skip_cnt`≠0, otherwise to CAPTURE.
- SKIP: beats are discarded. `samp_idx` counts 0..FFT_LEN-1 and wraps. At each wrap `skip_cnt` decrements. When it reaches 0, go to CAPTURE on the next beat boundary.
- CAPTURE: each beat is written to `ram[wr_addr]` and `wr_addr` increments.
  - When `samp_idx`=FFT_LEN-1, `frame_cnt` increments.
  - When `wr_addr`=DEPTH-1 is written, go to FULL; `full` rises the next cycle.
- FULL: no writes are performed. `arm` restarts the sequence exactly as from IDLE. RAM contents are retained until overwritten.
- `arm` while `busy` is ignored.
- An `arm` coincident with the last CAPTURE write is ignored; the block still goes to FULL.
- Framing check, active in SKIP and CAPTURE: `tlast_err` is set if an accepted beat has `tlast`=1 at `samp_idx`≠FFT_LEN-1, or `tlast`=0 at `samp_idx`=FFT_LEN-1. The count continues on `samp_idx`; there is no resync.
- `s_axis_tready` = !rst & !(FULL & HOLD_ON_FULL).
- Readback is valid in any state. A simultaneous write and read of the same address returns the old data (read-first).

## Timing
- Values after reset: `busy`=0, `full`=0, `frame_cnt`=0, `tlast_err`=0, `rd_data`=0, state IDLE. `s_axis_tready` is 0 during `rst` and 1 otherwise.
- A beat accepted on the cycle after the `arm` edge is eligible for ALIGN/SKIP/CAPTURE. A beat on the same edge as `arm` is discarded.
- RAM write latency is 0: the data is visible on the readback port 1 cycle after the write edge.
- Readback latency is 1 cycle from `rd_addr` to `rd_data`.
- `full`, `frame_cnt` and `tlast_err` are registered and update 1 cycle after the causing beat.
- `rst` mid-capture aborts to IDLE on the next edge and clears all status. RAM is not cleared.
- Zero-length gaps (`tvalid` low) hold all counters.

## Configuration
- `CAPTURE_TLAST_ALIGN_EN` defined: ALIGN discards beats until an accepted beat with `tlast`=1, then exits, so capture starts on the following beat (bin 0).
- `CAPTURE_TLAST_ALIGN_EN` undefined: ALIGN exits immediately, so the first accepted beat after `arm` is treated as bin 0. The framing check is still active.

## Test plan
- FFT_LEN=8, FRAMES=2, align off, skip=0. Arm, then stream the ramp 0..15 continuously → `ram[i]`=i, `full` rises 1 cycle after beat 15, `frame_cnt`=2, `tlast_err`=0.
- Align on. Arm at stream index 3 of the ramp, with `tlast` every 8 beats → `ram[0]`=8, `ram[15]`=23.
- skip=2, align off, stream with `tvalid` toggling every other cycle → `ram[0]`=16, `frame_cnt`=2 at full, and the total cycle count doubles compared with continuous streaming.
- `tlast` injected at index 5 of captured frame 0 → `tlast_err`=1 one cycle later and stays set. Capture still completes with 16 words.
- HOLD_ON_FULL=1: after `full`, `s_axis_tready`=0. A second `arm` gives `tready`=1 the next cycle, and `full`, `frame_cnt` and `tlast_err` all clear.
- Assert `rst` after 5 captured beats → next cycle `busy`=0, `frame_cnt`=0. `rd_addr`=2 still returns the previously written word.
